// File: rtl/alu_pkg.sv
// Shared constants and decoded-instruction type for the ALU operand fetch stage.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int NREGS   = 8;
   localparam int REG_AW  = 3;
   localparam int IMM_W   = 16;
   localparam int INSTR_W = 32;

   localparam logic [2:0] OP_ADD = 3'h0;
   localparam logic [2:0] OP_SUB = 3'h1;
   localparam logic [2:0] OP_MUL = 3'h2;
   localparam logic [2:0] OP_DIV = 3'h3;
   localparam logic [2:0] OP_AND = 3'h4;
   localparam logic [2:0] OP_OR  = 3'h5;
   localparam logic [2:0] OP_NOT = 3'h6;
   localparam logic [2:0] OP_XOR = 3'h7;

   // Instruction word field positions
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 29;
   localparam int RD_MSB  = 28;
   localparam int RD_LSB  = 26;
   localparam int RS1_MSB = 25;
   localparam int RS1_LSB = 23;
   localparam int RS2_MSB = 22;
   localparam int RS2_LSB = 20;
   localparam int ISEL_BIT = 19;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic [2:0]        op;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              imm_sel;
      logic [IMM_W-1:0]  imm;
   } instr_t;

   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 2-read / 1-write register file; r0 reads zero, reads see a same-cycle write.
module alu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8,
   parameter int REG_AW = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr1_i,
   input  logic [REG_AW-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o
);

   logic [NREGS-1:0][DATA_W-1:0] regs_q;

   // Storage: r0 is never written so it stays at its reset value of zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        regs_q <= '0;
      else if (we_i && waddr_i != '0)    regs_q[waddr_i] <= wdata_i;
   end

   // Read ports with write-first bypass; index 0 always reads zero
   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (raddr1_i != '0)
         rdata1_o = (we_i && waddr_i == raddr1_i) ? wdata_i : regs_q[raddr1_i];
      if (raddr2_i != '0)
         rdata2_o = (we_i && waddr_i == raddr2_i) ? wdata_i : regs_q[raddr2_i];
   end

endmodule

// File: rtl/alu_operand_fetch.sv
// Issue stage: decode, scoreboard hazard check, operand read and ALU output register.
module alu_operand_fetch
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_operation,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [REG_AW-1:0] out_rd,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   instr_t            ins;
   logic [DATA_W-1:0] rs1_val, rs2_val;
   logic              raw1, raw2, waw, hazard, accept;
   logic [NREGS-1:0]  pend_q, pend_d;
   logic              valid_q, valid_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              unused_bits;

   assign ins.op      = in_instr[OP_MSB:OP_LSB];
   assign ins.rd      = in_instr[RD_MSB:RD_LSB];
   assign ins.rs1     = in_instr[RS1_MSB:RS1_LSB];
   assign ins.rs2     = in_instr[RS2_MSB:RS2_LSB];
   assign ins.imm_sel = in_instr[ISEL_BIT];
   assign ins.imm     = in_instr[IMM_MSB:IMM_LSB];
   assign unused_bits = ^in_instr[18:16];

   alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (wb_en),
      .waddr_i  (wb_addr),
      .wdata_i  (wb_data),
      .raddr1_i (ins.rs1),
      .raddr2_i (ins.rs2),
      .rdata1_o (rs1_val),
      .rdata2_o (rs2_val)
   );

   // Hazards: a pending source/destination is fine if its writeback lands this cycle
   always_comb begin
      raw1   = (ins.rs1 != '0) && pend_q[ins.rs1] && !(wb_en && wb_addr == ins.rs1);
      raw2   = !ins.imm_sel && (ins.op != OP_NOT) && (ins.rs2 != '0) && pend_q[ins.rs2]
               && !(wb_en && wb_addr == ins.rs2);
      waw    = (ins.rd != '0) && pend_q[ins.rd] && !(wb_en && wb_addr == ins.rd);
      hazard = raw1 | raw2 | waw;
   end

   assign in_ready = rst_n & (~valid_q | out_ready) & ~hazard;
   assign accept   = in_valid & in_ready;

   // Scoreboard next state: writeback clears, a new producer sets (set wins)
   always_comb begin
      pend_d = pend_q;
      if (wb_en)  pend_d[wb_addr] = 1'b0;
      if (accept) pend_d[ins.rd]  = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Output register next state: load on accept, hold under backpressure
   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      rd_d    = rd_q;
      if (accept) begin
         valid_d = 1'b1;
         op_d    = ins.op;
         op1_d   = rs1_val;
         op2_d   = ins.imm_sel ? sext_imm(ins.imm) : rs2_val;
         rd_d    = ins.rd;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= '0;
         valid_q <= 1'b0;
         op_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         rd_q    <= '0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rd_q    <= rd_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_operation = op_q;
   assign out_op1       = op1_q;
   assign out_op2       = op2_q;
   assign out_rd        = rd_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed + random bench for alu_operand_fetch against a behavioural model.
module tb_alu_operand_fetch;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
   logic [31:0] in_instr = '0, wb_data = '0;
   logic [2:0]  wb_addr = '0;
   wire         in_ready, out_valid;
   wire  [2:0]  out_operation, out_rd;
   wire  [31:0] out_op1, out_op2;

   always #5 clk = ~clk;

   alu_operand_fetch dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_operation(out_operation),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   int npass = 0, nfail = 0, nchk = 0;

   // Behavioural model: architectural registers, pending set, and the issued op
   logic [31:0] mreg [8];
   bit          mpend [8];
   bit          mvalid;
   logic [2:0]  mop, mrd;
   logic [31:0] mop1, mop2;
   bit          dut_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      nchk++;
      assert (obs === want) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                      input int isel, input logic [15:0] imm);
      return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], isel[0], 3'b000, imm};
   endfunction

   task automatic mreset();
      for (int i = 0; i < 8; i++) begin mreg[i] = '0; mpend[i] = 0; end
      mvalid = 0; mop = '0; mrd = '0; mop1 = '0; mop2 = '0;
   endtask

   function automatic bit wb_hits(input logic [2:0] r);
      return wb_en && wb_addr == r;
   endfunction

   function automatic logic [31:0] mread(input logic [2:0] r);
      if (r == 0)     return '0;
      if (wb_hits(r)) return wb_data;
      return mreg[r];
   endfunction

   // A register blocks issue only if its producer is outstanding and not writing back now
   function automatic bit blocked(input logic [2:0] r);
      return r != 0 && mpend[r] && !wb_hits(r);
   endfunction

   function automatic bit mready();
      logic [2:0] op, rd, rs1, rs2;
      bit stall;
      op = in_instr[31:29]; rd = in_instr[28:26]; rs1 = in_instr[25:23]; rs2 = in_instr[22:20];
      stall = blocked(rs1) || blocked(rd) || (!in_instr[19] && op != 3'd6 && blocked(rs2));
      return (!mvalid || out_ready) && !stall;
   endfunction

   task automatic drive(input bit v, input logic [31:0] ins, input bit ordy,
                        input bit we, input logic [2:0] wa, input logic [31:0] wd);
      in_valid = v; in_instr = ins; out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
   endtask

   // One clock: check DUT against model mid-cycle, then advance the model across the edge
   task automatic cycle();
      bit          erdy, acc, nvalid;
      logic [2:0]  nop, nrd;
      logic [31:0] nop1, nop2;
      #3;
      erdy = mready();
      chk("in_ready", {31'b0, in_ready}, {31'b0, erdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
      chk("out_operation", {29'b0, out_operation}, {29'b0, mop});
      chk("out_op1", out_op1, mop1);
      chk("out_op2", out_op2, mop2);
      chk("out_rd", {29'b0, out_rd}, {29'b0, mrd});
      dut_acc = in_valid && in_ready;
      acc = in_valid && erdy;
      nvalid = mvalid; nop = mop; nrd = mrd; nop1 = mop1; nop2 = mop2;
      if (acc) begin
         nvalid = 1;
         nop  = in_instr[31:29];
         nrd  = in_instr[28:26];
         nop1 = mread(in_instr[25:23]);
         nop2 = in_instr[19] ? {{16{in_instr[15]}}, in_instr[15:0]} : mread(in_instr[22:20]);
      end else if (out_ready) begin
         nvalid = 0;
      end
      @(posedge clk);
      if (wb_en && wb_addr != 0) begin mreg[wb_addr] = wb_data; mpend[wb_addr] = 0; end
      if (acc && nrd != 0) mpend[nrd] = 1;
      mvalid = nvalid; mop = nop; mrd = nrd; mop1 = nop1; mop2 = nop2;
      #1;
   endtask

   initial begin
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_op1", out_op1, 32'd0);
      rst_n = 1'b1;

      // Async reset while an op is presented
      drive(1, mk(0, 1, 0, 0, 1, 16'h0007), 1, 0, 0, 0);
      cycle();
      chk("t1_pre_valid", {31'b0, out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("t1_rst_ready", {31'b0, in_ready}, 32'd0);
      mreset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int r = 1; r < 8; r++) begin
         drive(1, mk(4, 0, r, r, 0, 16'h0), 1, 0, 0, 0);
         cycle();
         chk("t1_op1_zero", out_op1, 32'd0);
         chk("t1_op2_zero", out_op2, 32'd0);
      end

      // Immediate sign extension with a register value
      drive(0, 0, 1, 1, 3'd1, 32'h5);
      cycle();
      drive(1, mk(0, 2, 1, 0, 1, 16'hFFFF), 1, 0, 0, 0);
      cycle();
      chk("t2_valid", {31'b0, out_valid}, 32'd1);
      chk("t2_op1", out_op1, 32'h5);
      chk("t2_op2", out_op2, 32'hFFFF_FFFF);
      chk("t2_operation", {29'b0, out_operation}, 32'd0);
      chk("t2_rd", {29'b0, out_rd}, 32'd2);
      drive(0, 0, 1, 1, 3'd2, 32'h22);
      cycle();

      // RAW stall resolved by a same-cycle writeback
      drive(1, mk(0, 3, 0, 0, 1, 16'h1), 1, 0, 0, 0);
      cycle();
      drive(1, mk(0, 7, 3, 0, 1, 16'h1), 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_stall", {31'b0, dut_acc}, 32'd0);
      end
      drive(1, mk(0, 7, 3, 0, 1, 16'h1), 1, 1, 3'd3, 32'h1234);
      cycle();
      chk("t3_accept", {31'b0, dut_acc}, 32'd1);
      chk("t3_op1", out_op1, 32'h1234);
      drive(0, 0, 1, 1, 3'd7, 32'h77);
      cycle();

      // Backpressure, then full-rate drain
      drive(1, mk(1, 1, 0, 0, 1, 16'd10), 0, 0, 0, 0);
      cycle();
      drive(1, mk(1, 2, 0, 0, 1, 16'd20), 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t4_hold_ready", {31'b0, in_ready}, 32'd0);
         chk("t4_hold_op2", out_op2, 32'd10);
      end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) drive(1, mk(k, 0, 0, 0, 1, 16'(100 + k)), 1, 0, 0, 0);
         else       out_ready = 1;
         cycle();
         chk("t4_b2b_acc", {31'b0, dut_acc}, 32'd1);
         chk("t4_b2b_op2", out_op2, (k == 0) ? 32'd20 : 32'(100 + k));
      end
      drive(0, 0, 1, 1, 3'd1, 32'h11);
      cycle();
      drive(0, 0, 1, 1, 3'd2, 32'h22);
      cycle();

      // rd=0 never creates a dependency; WAW stall and set-wins on same-cycle clear
      drive(1, mk(0, 0, 0, 0, 1, 16'h5), 1, 0, 0, 0);
      cycle();
      drive(1, mk(0, 1, 0, 0, 0, 16'h0), 1, 0, 0, 0);
      cycle();
      chk("t5_r0_acc", {31'b0, dut_acc}, 32'd1);
      chk("t5_r0_op1", out_op1, 32'd0);
      drive(0, 0, 1, 1, 3'd1, 32'h0);
      cycle();
      drive(1, mk(0, 4, 0, 0, 1, 16'h1), 1, 0, 0, 0);
      cycle();
      drive(1, mk(0, 4, 0, 0, 1, 16'h2), 1, 0, 0, 0);
      cycle();
      chk("t5_waw_stall", {31'b0, dut_acc}, 32'd0);
      drive(1, mk(0, 4, 0, 0, 1, 16'h2), 1, 1, 3'd4, 32'h9);
      cycle();
      chk("t5_waw_acc", {31'b0, dut_acc}, 32'd1);
      drive(1, mk(0, 1, 4, 0, 1, 16'h0), 1, 0, 0, 0);
      cycle();
      chk("t5_pend_kept", {31'b0, dut_acc}, 32'd0);
      drive(1, mk(0, 1, 4, 0, 1, 16'h0), 1, 1, 3'd4, 32'hABCD);
      cycle();
      chk("t5_fwd_acc", {31'b0, dut_acc}, 32'd1);
      chk("t5_fwd_op1", out_op1, 32'hABCD);

      // NOT ignores a pending rs2
      drive(1, mk(0, 5, 0, 0, 1, 16'h0), 1, 0, 0, 0);
      cycle();
      drive(1, mk(6, 6, 0, 5, 0, 16'h0), 1, 0, 0, 0);
      cycle();
      chk("t6_not_acc", {31'b0, dut_acc}, 32'd1);
      chk("t6_not_op", {29'b0, out_operation}, 32'd6);

      // Random traffic; an unaccepted instruction is usually held
      for (int n = 0; n < 400; n++) begin
         if (!in_valid || dut_acc) in_instr = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         wb_en     = $urandom_range(0, 1);
         wb_addr   = 3'($urandom_range(0, 7));
         wb_data   = $urandom;
         cycle();
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
